// File: rtl/epoch_collector.sv
// epoch_collector: ping-pong epoch buffer that collects filtered samples and drains whole epochs downstream
module epoch_collector #(
  parameter int EPOCH_LENGTH = 256,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  epoch_start,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [1:0]            bank_full,
  output logic                  overrun,
  output logic [15:0]           epoch_count
);
  localparam int IW = $clog2(EPOCH_LENGTH);
  localparam logic IDLE = 1'b0;
  localparam logic DRAIN = 1'b1;
  localparam logic [IW-1:0] LAST = IW'(EPOCH_LENGTH - 1);

  logic [DATA_WIDTH-1:0] mem [2*EPOCH_LENGTH];
  logic state, wr_bank, rd_bank;
  logic [IW-1:0] wr_idx, rd_idx, rd_addr;
  logic wr_en, wr_done, rd_start, rd_acc, rd_done;
  logic [1:0] set_full, clr_full;

  always_comb begin
    wr_en = enable && !epoch_start && in_valid && !bank_full[wr_bank];
    wr_done = wr_en && wr_idx == LAST;
    rd_start = state == IDLE && bank_full[rd_bank];
    rd_acc = state == DRAIN && out_valid && out_ready;
    rd_done = rd_acc && rd_idx == LAST;
    rd_addr = rd_start ? '0 : rd_idx + 1'b1;
    set_full = wr_done ? 2'b01 << wr_bank : 2'b00;
    clr_full = rd_done ? 2'b01 << rd_bank : 2'b00;
  end

  assign out_last = out_valid && rd_idx == LAST;

  always_ff @(posedge clk)
    if (wr_en) mem[{wr_bank, wr_idx}] <= in_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      out_valid <= 1'b0;
      out_data <= '0;
      bank_full <= 2'b00;
      overrun <= 1'b0;
      epoch_count <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_idx <= '0;
      rd_idx <= '0;
    end else begin
      // writer set and reader clear always target different banks, so both apply
      bank_full <= (bank_full | set_full) & ~clr_full;
      if (!enable || epoch_start) wr_idx <= '0;
      else if (in_valid && bank_full[wr_bank]) overrun <= 1'b1;
      else if (wr_en) begin
        wr_idx <= wr_idx + 1'b1;
        if (wr_done) begin
          wr_bank <= ~wr_bank;
          epoch_count <= epoch_count + 16'd1;
        end
      end
      if (rd_start) begin
        state <= DRAIN;
        rd_idx <= '0;
        out_valid <= 1'b1;
        out_data <= mem[{rd_bank, rd_addr}];
      end else if (rd_done) begin
        state <= IDLE;
        out_valid <= 1'b0;
        rd_bank <= ~rd_bank;
      end else if (rd_acc) begin
        rd_idx <= rd_addr;
        out_data <= mem[{rd_bank, rd_addr}];
      end
    end
  end
endmodule

// File: tb/tb_epoch_collector.sv
// tb_epoch_collector: randomized self-checking bench for epoch_collector against an epoch-level queue model
module tb_epoch_collector;
  localparam int L = 256;
  logic clk = 0, rst = 1, enable = 0, epoch_start = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_data = 0;
  logic [31:0] out_data;
  logic out_valid, out_last, overrun;
  logic [1:0] bank_full;
  logic [15:0] epoch_count;

  epoch_collector dut (
    .clk(clk), .rst(rst), .enable(enable), .epoch_start(epoch_start), .in_data(in_data),
    .in_valid(in_valid), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .bank_full(bank_full), .overrun(overrun), .epoch_count(epoch_count)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [31:0] expq[$];
  logic [31:0] partial[$];
  int pending = 0, beat = 0;
  logic m_ovr = 0;
  logic [15:0] m_cnt = 0;

  task automatic model_clear();
    expq.delete(); partial.delete();
    pending = 0; beat = 0; m_ovr = 0; m_cnt = 0;
  endtask

  // one clock cycle: drive inputs at negedge, check current outputs, advance model across the edge
  task automatic cyc(input logic en, input logic st, input logic v, input logic [31:0] d, input logic rdy);
    enable = en; epoch_start = st; in_valid = v; in_data = d; out_ready = rdy;
    #1;
    total++;
    if (out_valid === 1'b1 && pending == 0) begin
      bad++; $display("FAIL spurious_valid out_valid=%b with no full epoch", out_valid);
    end
    if (out_valid === 1'b1 && pending > 0) begin
      total += 2;
      if (out_data !== expq[0]) begin
        bad++; $display("FAIL out_data beat=%0d got=%h exp=%h", beat, out_data, expq[0]);
      end
      if (out_last !== (beat == L - 1)) begin
        bad++; $display("FAIL out_last beat=%0d got=%b exp=%b", beat, out_last, beat == L - 1);
      end
    end else begin
      total++;
      if (out_last !== 1'b0) begin bad++; $display("FAIL out_last_idle got=%b exp=0", out_last); end
    end
    total += 3;
    if ($countones(bank_full) != pending) begin
      bad++; $display("FAIL bank_full got=%b exp_count=%0d", bank_full, pending);
    end
    if (overrun !== m_ovr) begin bad++; $display("FAIL overrun got=%b exp=%b", overrun, m_ovr); end
    if (epoch_count !== m_cnt) begin
      bad++; $display("FAIL epoch_count got=%0d exp=%0d", epoch_count, m_cnt);
    end
    if (!en || st) partial.delete();
    else if (v) begin
      if (pending == 2) m_ovr = 1;
      else begin
        partial.push_back(d);
        if (partial.size() == L) begin
          foreach (partial[i]) expq.push_back(partial[i]);
          partial.delete(); pending++; m_cnt++;
        end
      end
    end
    if (out_valid === 1'b1 && rdy && pending > 0) begin
      void'(expq.pop_front());
      beat++;
      if (beat == L) begin beat = 0; pending--; end
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic drain(input int pct);
    int n = 0;
    while (expq.size() > 0 && n < 4000) begin
      cyc(1, 0, 0, 0, $urandom_range(99) < pct);
      n++;
    end
    total++;
    if (expq.size() != 0) begin bad++; $display("FAIL drain_timeout left=%0d exp=0", expq.size()); end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1; #1;
    model_clear();
    total += 5;
    if (out_valid !== 0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    if (out_last !== 0) begin bad++; $display("FAIL rst_out_last got=%b exp=0", out_last); end
    if (bank_full !== 0) begin bad++; $display("FAIL rst_bank_full got=%b exp=00", bank_full); end
    if (overrun !== 0) begin bad++; $display("FAIL rst_overrun got=%b exp=0", overrun); end
    if (epoch_count !== 0) begin bad++; $display("FAIL rst_epoch_count got=%0d exp=0", epoch_count); end
    @(posedge clk); @(negedge clk);
    total++;
    if (out_data !== 0) begin bad++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
    rst = 0;
  endtask

  task automatic test_reset(); do_reset(); endtask

  task automatic test_ramp();
    for (int k = 0; k < L; k++) cyc(1, 0, 1, 32'(k - 128), 1);
    total++;
    if (out_valid !== 0) begin bad++; $display("FAIL latency_1 out_valid got=%b exp=0", out_valid); end
    cyc(1, 0, 0, 0, 0);
    total++;
    if (out_valid !== 1) begin bad++; $display("FAIL latency_2 out_valid got=%b exp=1", out_valid); end
    total++;
    if (out_data !== 32'hFFFF_FF80) begin bad++; $display("FAIL ramp_first got=%h exp=ffffff80", out_data); end
    drain(100);
    cyc(1, 0, 0, 0, 1);
    total += 2;
    if (bank_full !== 2'b00) begin bad++; $display("FAIL ramp_bank_full got=%b exp=00", bank_full); end
    if (epoch_count !== 16'd1) begin bad++; $display("FAIL ramp_count got=%0d exp=1", epoch_count); end
  endtask

  task automatic test_overrun();
    do_reset();
    for (int k = 0; k < 2 * L; k++) cyc(1, 0, 1, $urandom, 0);
    total += 3;
    if (bank_full !== 2'b11) begin bad++; $display("FAIL ovr_full got=%b exp=11", bank_full); end
    if (epoch_count !== 16'd2) begin bad++; $display("FAIL ovr_count got=%0d exp=2", epoch_count); end
    if (overrun !== 0) begin bad++; $display("FAIL ovr_early got=%b exp=0", overrun); end
    cyc(1, 0, 1, 32'hDEAD_BEEF, 0);
    total++;
    if (overrun !== 1) begin bad++; $display("FAIL ovr_set got=%b exp=1", overrun); end
    drain(100);
  endtask

  task automatic test_epoch_start();
    do_reset();
    for (int k = 0; k < 100; k++) cyc(1, 0, 1, $urandom, 1);
    cyc(1, 1, 1, 32'h1234_5678, 1);
    for (int k = 0; k < L; k++) cyc(1, 0, 1, $urandom, 1);
    drain(100);
    total += 2;
    if (overrun !== 0) begin bad++; $display("FAIL es_overrun got=%b exp=0", overrun); end
    if (epoch_count !== 16'd1) begin bad++; $display("FAIL es_count got=%0d exp=1", epoch_count); end
  endtask

  task automatic test_random();
    int n = 0;
    logic [15:0] goal;
    do_reset();
    for (int k = 0; k < 37; k++) cyc(0, 0, 1, $urandom, 1);
    goal = m_cnt + 16'd8;
    while (m_cnt != goal && n < 20000) begin
      cyc(1, 0, $urandom_range(3) == 0, $urandom, $urandom_range(1));
      n++;
    end
    total++;
    if (m_cnt != goal) begin bad++; $display("FAIL random_timeout epochs=%0d exp=%0d", m_cnt, goal); end
    drain(50);
  endtask

  task automatic test_reset_mid_drain();
    int n = 0;
    do_reset();
    for (int k = 0; k < L; k++) cyc(1, 0, 1, $urandom, 0);
    while (beat != 50 && n < 400) begin cyc(1, 0, 0, 0, 1); n++; end
    total++;
    if (beat != 50) begin bad++; $display("FAIL mid_reach beat=%0d exp=50", beat); end
    do_reset();
    for (int k = 0; k < 5; k++) cyc(1, 0, 0, 0, 1);
    for (int k = 0; k < L; k++) cyc(1, 0, 1, $urandom, 1);
    drain(100);
    cyc(1, 0, 0, 0, 1);
    total += 2;
    if (epoch_count !== 16'd1) begin bad++; $display("FAIL mid_count got=%0d exp=1", epoch_count); end
    if (out_valid !== 0) begin bad++; $display("FAIL mid_valid got=%b exp=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_overrun();
    test_epoch_start();
    test_random();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
